xy_addr_gen: RTL and testbench
==============================

XY_ADDR_GEN -- requirements
Module: xy_addr_gen

Interface
REQ-001 Parameter X_WIDTH, default 8: width of x_addr.
REQ-002 Parameter Y_WIDTH, default 8: width of y_addr.
REQ-003 Parameter X_MAX, default 240: last x value; must satisfy X_MAX < 2**X_WIDTH.
REQ-004 Parameter Y_MAX, default 160: last y value; must satisfy Y_MAX < 2**Y_WIDTH.
REQ-005 Parameter LIN_WIDTH, default 16: width of lin_addr; must hold (X_MAX+1)*(Y_MAX+1)-1.
REQ-006 clock  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  pulse: begin a scan from (0,0).
REQ-009 abort  input  1  synchronous: terminate the scan and return to IDLE.
REQ-010 enable  input  1  advance one position this cycle.
REQ-011 cont  input  1  1 = wrap and keep scanning at frame end; 0 = single frame.
REQ-012 mode  input  1  0 = row-major (x fastest); 1 = column-major (y fastest); sampled on start.
REQ-013 x_addr  output  X_WIDTH  current x position.
REQ-014 y_addr  output  Y_WIDTH  current y position.
REQ-015 valid  output  1  x_addr/y_addr hold a live scan position.
REQ-016 line_end  output  1  valid and the fast axis is at its maximum.
REQ-017 frame_end  output  1  valid and both axes are at their maxima.
REQ-018 lin_addr  output  LIN_WIDTH  linear address y*(X_MAX+1)+x; see Configuration.

Function
REQ-019 The FSM SHALL have two states, IDLE and RUN; valid SHALL be 1 exactly in RUN.
REQ-020 In IDLE, start=1 SHALL move the FSM to RUN at the next edge, with x_addr=0, y_addr=0 and mode latched into an internal mode register.
REQ-021 In RUN, start SHALL be ignored; mode input changes SHALL have no effect until the next start.
REQ-022 In RUN with enable=0, x_addr and y_addr SHALL hold.
REQ-023 Row-major step: x<X_MAX gives x+1; x=X_MAX gives x=0 and y+1.
REQ-024 Column-major step: y<Y_MAX gives y+1; y=Y_MAX gives y=0 and x+1.
REQ-025 line_end SHALL be combinational from registered state: row-major x_addr==X_MAX; column-major y_addr==Y_MAX; gated by valid.
REQ-026 frame_end SHALL be combinational: valid && x_addr==X_MAX && y_addr==Y_MAX, independent of mode.
REQ-027 On enable with frame_end=1: cont=1 SHALL give (0,0) and remain in RUN; cont=0 SHALL give IDLE with x_addr=y_addr=0.
REQ-028 abort=1 SHALL force IDLE with x_addr=y_addr=0 at the next edge, taking priority over start and enable in either state.
REQ-029 Coordinates SHALL never exceed X_MAX/Y_MAX; out-of-range values are unreachable.
REQ-030 The latency from start to the first valid position SHALL be one cycle; each enabled step SHALL take one cycle.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, x_addr=0, y_addr=0, mode register=0, valid=0, line_end=0, frame_end=0 and lin_addr=0.
REQ-032 Reset release SHALL take effect on the first clock edge with reset_n=1; no scan starts without start.

Configuration
REQ-033 Macro XY_ADDR_LINEAR_EN defined: lin_addr SHALL equal y_addr*(X_MAX+1)+x_addr, computed combinationally from registered coordinates and truncated to LIN_WIDTH.
REQ-034 Macro XY_ADDR_LINEAR_EN undefined: lin_addr SHALL be driven constant 0 and no multiplier logic SHALL be synthesised.

Verification (X_MAX=3, Y_MAX=2 unless noted)
REQ-035 Row-major, cont=0, start then enable held: sequence (0,0),(1,0),(2,0),(3,0),(0,1)..(3,2); line_end on x=3; frame_end on (3,2); next cycle valid=0.
REQ-036 Column-major, start with mode=1: sequence (0,0),(0,1),(0,2),(1,0)..(3,2); line_end on y=2; toggling mode mid-scan causes no change.
REQ-037 cont=1: after (3,2) with enable the position returns to (0,0), valid stays 1, frame_end pulses once per 12 enabled steps.
REQ-038 enable toggled 1,0,0,1 from (1,0): positions (2,0),(2,0),(2,0),(3,0); start asserted mid-scan is ignored.
REQ-039 abort and start asserted together at (2,1): next cycle IDLE, (0,0), valid=0; reset_n pulsed low mid-cycle clears all outputs immediately, without waiting for a clock edge.
REQ-040 With XY_ADDR_LINEAR_EN defined, at (3,2) lin_addr=11 and at (1,1) lin_addr=5; with the macro undefined, lin_addr=0 throughout.

Source files
------------

// File: rtl/xy_addr_gen.sv
// xy_addr_gen: 2-D scan address generator over a (X_MAX+1) x (Y_MAX+1) grid.
// Scans row-major (x fastest) or column-major (y fastest), optionally wrapping
// continuously at frame end, with synchronous abort and per-cycle enable.
//
// Optional feature macro: XY_ADDR_LINEAR_EN
//   defined   -> lin_addr = y_addr*(X_MAX+1) + x_addr (truncated to LIN_WIDTH)
//   undefined -> lin_addr tied to 0, no multiplier
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a scan from (0,0); ignored while scanning
//   abort      in   return to idle at next edge (highest priority)
//   enable     in   advance one position this cycle
//   cont       in   1 = wrap at frame end, 0 = stop after one frame
//   mode       in   0 = row-major, 1 = column-major; latched on start
//   x_addr     out  current x position
//   y_addr     out  current y position
//   valid      out  a scan is live
//   line_end   out  valid and fast axis at its maximum
//   frame_end  out  valid and both axes at their maxima
//   lin_addr   out  linear address (see macro above)
module xy_addr_gen #(
    parameter int unsigned X_WIDTH   = 8,
    parameter int unsigned Y_WIDTH   = 8,
    parameter int unsigned X_MAX     = 240,
    parameter int unsigned Y_MAX     = 160,
    parameter int unsigned LIN_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 enable,
    input  logic                 cont,
    input  logic                 mode,
    output logic [X_WIDTH-1:0]   x_addr,
    output logic [Y_WIDTH-1:0]   y_addr,
    output logic                 valid,
    output logic                 line_end,
    output logic                 frame_end,
    output logic [LIN_WIDTH-1:0] lin_addr
);

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [X_WIDTH-1:0]   x_q, x_d;
    logic [Y_WIDTH-1:0]   y_q, y_d;
    logic                 mode_q, mode_d;
    logic                 x_at_max;
    logic                 y_at_max;
    logic                 run;

    // Status flags decoded from registered state only
    assign x_at_max  = (x_q == X_LAST);
    assign y_at_max  = (y_q == Y_LAST);
    assign run       = (state_q == RUN);

    assign x_addr    = x_q;
    assign y_addr    = y_q;
    assign valid     = run;
    assign line_end  = run && (mode_q ? y_at_max : x_at_max);
    assign frame_end = run && x_at_max && y_at_max;

    // State and coordinate registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and next-coordinate logic; abort overrides everything
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;

        if (abort) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        x_d     = '0;
                        y_d     = '0;
                        mode_d  = mode;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (x_at_max && y_at_max) begin
                            // Frame complete: wrap or stop, both land on (0,0)
                            x_d = '0;
                            y_d = '0;
                            if (!cont) begin
                                state_d = IDLE;
                            end
                        end else if (!mode_q) begin
                            if (x_at_max) begin
                                x_d = '0;
                                y_d = y_q + Y_WIDTH'(1);
                            end else begin
                                x_d = x_q + X_WIDTH'(1);
                            end
                        end else begin
                            if (y_at_max) begin
                                y_d = '0;
                                x_d = x_q + X_WIDTH'(1);
                            end else begin
                                y_d = y_q + Y_WIDTH'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end
            endcase
        end
    end

`ifdef XY_ADDR_LINEAR_EN
    localparam int unsigned X_SPAN = X_MAX + 1;

    // Row-major linear address from the registered coordinates
    assign lin_addr = LIN_WIDTH'(y_q) * LIN_WIDTH'(X_SPAN) + LIN_WIDTH'(x_q);
`else
    assign lin_addr = '0;
`endif

endmodule

// File: tb/tb_xy_addr_gen.sv
// Self-checking bench for xy_addr_gen on a 4 x 3 grid (X_MAX=3, Y_MAX=2).
module tb_xy_addr_gen;

    localparam int NX   = 4;
    localparam int NY   = 3;
    localparam int NPOS = NX * NY;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, abort, enable, cont, mode;
    logic [7:0]  x_addr, y_addr;
    logic        valid, line_end, frame_end;
    logic [15:0] lin_addr;

    int checks = 0;
    int errors = 0;

    xy_addr_gen #(
        .X_WIDTH(8), .Y_WIDTH(8), .X_MAX(3), .Y_MAX(2), .LIN_WIDTH(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .enable(enable), .cont(cont), .mode(mode),
        .x_addr(x_addr), .y_addr(y_addr), .valid(valid),
        .line_end(line_end), .frame_end(frame_end), .lin_addr(lin_addr)
    );

    always #5 clock = ~clock;

    // Reference model: scan as an ordinal position within the frame
    bit m_run  = 1'b0;
    bit m_mode = 1'b0;
    int m_p    = 0;

    function automatic int m_x();
        return m_mode ? (m_p / NY) : (m_p % NX);
    endfunction

    function automatic int m_y();
        return m_mode ? (m_p % NY) : (m_p / NX);
    endfunction

    function automatic int exp_lin(int x, int y);
`ifdef XY_ADDR_LINEAR_EN
        return y * NX + x;
`else
        return 0 * (x + y);
`endif
    endfunction

    task automatic model_step();
        if (abort) begin
            m_run = 1'b0;
            m_p   = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run  = 1'b1;
                m_p    = 0;
                m_mode = mode;
            end
        end else if (enable) begin
            if (m_p == NPOS - 1) begin
                m_p = 0;
                if (!cont) m_run = 1'b0;
            end else begin
                m_p = m_p + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        bit le, fe;
        le = m_run && (m_mode ? (m_y() == NY - 1) : (m_x() == NX - 1));
        fe = m_run && (m_p == NPOS - 1);
        chk({tag, ".x"},         int'(x_addr),    m_x());
        chk({tag, ".y"},         int'(y_addr),    m_y());
        chk({tag, ".valid"},     int'(valid),     int'(m_run));
        chk({tag, ".line_end"},  int'(line_end),  int'(le));
        chk({tag, ".frame_end"}, int'(frame_end), int'(fe));
        chk({tag, ".lin"},       int'(lin_addr),  exp_lin(m_x(), m_y()));
    endtask

    task automatic set_in(bit s, bit a, bit e, bit c, bit m);
        start = s; abort = a; enable = e; cont = c; mode = m;
    endtask

    typedef struct {
        bit st, ab, en, co, md;
        int ex, ey;
        bit ev, ele, efe;
    } vec_t;

    function automatic vec_t mk(bit st, bit ab, bit en, bit co, bit md,
                                int ex, int ey, bit ev, bit ele, bit efe);
        vec_t v;
        v.st = st; v.ab = ab; v.en = en; v.co = co; v.md = md;
        v.ex = ex; v.ey = ey; v.ev = ev; v.ele = ele; v.efe = efe;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        int   fe_cnt;
        bit   all_valid;

        // One row-major frame, then enable gaps with an ignored start, then abort+start
        vecs.push_back(mk(1,0,0,0,0, 0,0, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 2,0, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 3,0, 1,1,0));
        vecs.push_back(mk(0,0,1,0,0, 0,1, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,1, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 2,1, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 3,1, 1,1,0));
        vecs.push_back(mk(0,0,1,0,0, 0,2, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,2, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 2,2, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 3,2, 1,1,1));
        vecs.push_back(mk(0,0,1,0,0, 0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 2,0, 1,0,0));
        vecs.push_back(mk(1,0,0,0,1, 2,0, 1,0,0));
        vecs.push_back(mk(0,0,0,0,0, 2,0, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 3,0, 1,1,0));
        vecs.push_back(mk(1,1,1,0,0, 0,0, 0,0,0));

        // Reset state, checked while reset is held
        reset_n = 1'b0;
        set_in(0,0,0,0,0);
        #12;
        check_model("reset");
        reset_n = 1'b1;
        tick();
        check_model("post_reset_idle");

        // Table-driven vectors
        foreach (vecs[i]) begin
            set_in(vecs[i].st, vecs[i].ab, vecs[i].en, vecs[i].co, vecs[i].md);
            tick();
            chk($sformatf("vec%0d.x", i),         int'(x_addr),    vecs[i].ex);
            chk($sformatf("vec%0d.y", i),         int'(y_addr),    vecs[i].ey);
            chk($sformatf("vec%0d.valid", i),     int'(valid),     int'(vecs[i].ev));
            chk($sformatf("vec%0d.line_end", i),  int'(line_end),  int'(vecs[i].ele));
            chk($sformatf("vec%0d.frame_end", i), int'(frame_end), int'(vecs[i].efe));
            chk($sformatf("vec%0d.lin", i),       int'(lin_addr),  exp_lin(vecs[i].ex, vecs[i].ey));
        end

        // Column-major frame with mode toggling mid-scan
        set_in(1,0,0,0,1);
        tick();
        check_model("col_start");
        for (int k = 1; k <= NPOS; k++) begin
            set_in(0, 0, 1, 0, 1'($urandom_range(0, 1)));
            tick();
            check_model($sformatf("col_step%0d", k));
            if (k == 2) begin
                chk("col_y_at_2", int'(y_addr), 2);
                chk("col_line_end_y2", int'(line_end), 1);
            end
            if (k == 3) chk("col_x_after_wrap", int'(x_addr), 1);
        end

        // Continuous scan: two frames, frame_end once per 12 steps
        set_in(1,0,0,1,0);
        tick();
        fe_cnt    = 0;
        all_valid = 1'b1;
        for (int k = 0; k < 2 * NPOS; k++) begin
            set_in(0,0,1,1,0);
            tick();
            if (frame_end === 1'b1) fe_cnt++;
            if (valid !== 1'b1) all_valid = 1'b0;
        end
        chk("cont_frame_pulses", fe_cnt, 2);
        chk("cont_valid_held", int'(all_valid), 1);
        check_model("cont_end");
        set_in(0,1,0,0,0);
        tick();
        check_model("cont_abort");

        // Abort together with start at (2,1)
        set_in(1,0,0,0,0);
        tick();
        for (int k = 0; k < 6; k++) begin
            set_in(0,0,1,0,0);
            tick();
        end
        chk("pos21.x", int'(x_addr), 2);
        chk("pos21.y", int'(y_addr), 1);
        set_in(1,1,1,0,0);
        tick();
        check_model("abort_start");
        chk("abort_valid", int'(valid), 0);

        // Linear address at (1,1), then asynchronous reset mid-cycle
        set_in(1,0,0,0,0);
        tick();
        for (int k = 0; k < 5; k++) begin
            set_in(0,0,1,0,0);
            tick();
        end
        chk("pos11.x", int'(x_addr), 1);
        chk("pos11.y", int'(y_addr), 1);
`ifdef XY_ADDR_LINEAR_EN
        chk("lin_at_11", int'(lin_addr), 5);
`else
        chk("lin_at_11", int'(lin_addr), 0);
`endif
        set_in(0,0,0,0,0);
        #2;
        reset_n = 1'b0;
        #1;
        m_run = 1'b0; m_p = 0; m_mode = 1'b0;
        check_model("async_reset");
        #2;
        reset_n = 1'b1;
        tick();
        check_model("reset_release_idle");

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            set_in(1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 31) == 0),
                   1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            tick();
            check_model($sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
